// File: rtl/shared_adder_pkg.sv
// shared_adder_pkg: shared constants and types for the shared adder arbiter
package shared_adder_pkg;
  localparam int N_REQ_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 8;
  typedef logic [$clog2(N_REQ_DEFAULT)-1:0] req_id_t;
  typedef struct packed {
    logic                     carry;
    logic [WIDTH_DEFAULT-1:0] sum;
  } sum_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after the last grant
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any_grant
);
  always_comb begin
    grant = '0;
    idx = '0;
    any_grant = 1'b0;
    // scan farthest first so the nearest requester after last wins
    for (int i = N; i >= 1; i--) begin
      if (en && req[(int'(last) + i) % N]) begin
        grant = '0;
        grant[(int'(last) + i) % N] = 1'b1;
        idx = ID_W'((int'(last) + i) % N);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin shared 8-bit adder with one-deep result register
module shared_adder_arbiter
  import shared_adder_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready
);
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] g_idx;
  logic            xfer;
  logic [WIDTH:0]  sum;
  logic            slot_free;
  assign slot_free = !res_valid || res_ready;
  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .en        (ena && slot_free),
    .last      (last_grant),
    .grant     (req_ready),
    .idx       (g_idx),
    .any_grant (xfer)
  );
  assign sum = {1'b0, req_a[int'(g_idx)*WIDTH +: WIDTH]} + {1'b0, req_b[int'(g_idx)*WIDTH +: WIDTH]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum <= '0;
      res_carry <= 1'b0;
      res_id <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_sum <= sum[WIDTH-1:0];
      res_carry <= sum[WIDTH];
      res_id <= g_idx;
      last_grant <= g_idx;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: directed scoreboard bench for shared_adder_arbiter
module tb_shared_adder_arbiter;
  import shared_adder_pkg::*;
  typedef struct packed {
    logic [1:0] id;
    sum_t       r;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        res_ready;
  exp_t        q[$];
  int          total = 0;
  int          passed = 0;
  shared_adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .res_ready (res_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask
  task automatic expect_res(input logic [1:0] id, input logic c, input logic [7:0] s);
    exp_t e;
    e.id = id;
    e.r.carry = c;
    e.r.sum = s;
    q.push_back(e);
  endtask
  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic c, input logic [7:0] s);
    set_req(i, a, b);
    req_valid = 4'b1 << i;
    #1;
    chk("issue_grant", req_ready, 4'b1 << i);
    expect_res(2'(i), c, s);
    tick;
    chk("issue_latency", res_valid, 1);
    req_valid = '0;
  endtask
  // monitor: a result leaves the DUT when valid and ready meet at the next edge
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got id %0d sum %0h with nothing expected", res_id, res_sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_id", res_id, e.id);
        chk("res_sum", res_sum, e.r.sum);
        chk("res_carry", res_carry, e.r.carry);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_id", res_id, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    issue(0, 8'h12, 8'h34, 1'b0, 8'h46);
    issue(1, 8'hFF, 8'h02, 1'b1, 8'h01);
    issue(2, 8'h80, 8'h80, 1'b1, 8'h00);
    issue(3, 8'hA5, 8'h5A, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * i + 1), 8'h01);
    for (int k = 0; k < 6; k++) expect_res(2'(k % 4), 1'b0, 8'(8'h10 * (k % 4) + 2));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", req_ready, 4'b1 << (k % 4));
      tick;
      chk("rr_no_bubble", res_valid, 1);
    end
    req_valid = '0;
    tick;
    res_ready = 1'b0;
    set_req(2, 8'h30, 8'h07);
    req_valid = 4'b0100;
    #1;
    chk("bp_first_grant", req_ready, 4'b0100);
    expect_res(2'd2, 1'b0, 8'h37);
    tick;
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", req_ready, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", res_sum, 8'h37);
      chk("bp_id", res_id, 2);
      tick;
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b1000);
    expect_res(2'd3, 1'b0, 8'h32);
    tick;
    req_valid = '0;
    chk("bp_no_bubble", res_valid, 1);
    tick;
    chk("drain_valid", res_valid, 0);
    res_ready = 1'b0;
    set_req(0, 8'h01, 8'h02);
    req_valid = 4'b0001;
    #1;
    chk("ena_setup_grant", req_ready, 4'b0001);
    expect_res(2'd0, 1'b0, 8'h03);
    tick;
    ena = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("ena_low_ready", req_ready, 0);
    tick;
    res_ready = 1'b1;
    #1;
    chk("ena_low_ready_slot_free", req_ready, 0);
    tick;
    chk("ena_low_popped", res_valid, 0);
    tick;
    chk("ena_low_still_idle", req_ready, 0);
    ena = 1'b1;
    #1;
    chk("ena_pointer_frozen", req_ready, 4'b0010);
    expect_res(2'd1, 1'b0, 8'h12);
    tick;
    req_valid = '0;
    tick;
    res_ready = 1'b0;
    set_req(2, 8'h44, 8'h44);
    req_valid = 4'b0100;
    tick;
    req_valid = '0;
    #1;
    chk("pre_reset_valid", res_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", res_valid, 0);
    chk("async_reset_sum", res_sum, 0);
    chk("async_reset_id", res_id, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_valid = 4'b0110;
    res_ready = 1'b1;
    #1;
    chk("post_reset_grant", req_ready, 4'b0010);
    expect_res(2'd1, 1'b0, 8'h12);
    tick;
    req_valid = '0;
    tick;
    tick;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
